// File: rtl/jump_charge_ctl_pkg.sv
// jump_charge_ctl_pkg: state/direction encodings shared by the jump sequencer
package jump_charge_ctl_pkg;
   typedef enum logic [2:0] {IDLE, CHARGE, LAUNCH, LIFT, AIR, LAND} jump_state_t;
   typedef enum logic [1:0] {DIR_UP = 2'b00, DIR_LEFT = 2'b01, DIR_RIGHT = 2'b10} jump_dir_t;
   function automatic jump_dir_t pick_dir(input logic l, input logic r);
      return (l && !r) ? DIR_LEFT : (r && !l) ? DIR_RIGHT : DIR_UP;
   endfunction
endpackage

// File: rtl/jump_charge_ctl_step_timer.sv
// jump_charge_ctl_step_timer: free-running step divider, restarted by clear_i
module jump_charge_ctl_step_timer #(
   parameter int CYCLES_PER_STEP = 400_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic step_tick_o
);
   localparam int CNT_W = CYCLES_PER_STEP > 1 ? $clog2(CYCLES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_STEP - 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = (clear_i || cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign step_tick_o = cnt_q == LAST;
endmodule

// File: rtl/jump_charge_ctl.sv
// jump_charge_ctl: space-held charge, launch pulse and flight/landing sequencing
module jump_charge_ctl
   import jump_charge_ctl_pkg::*;
#(
   parameter int CYCLES_PER_STEP = 400_000,
   parameter int POWER_W         = 8,
   parameter int POWER_MIN       = 10,
   parameter int POWER_MAX       = 100,
   parameter int LAND_STEPS      = 25,
   parameter int LIFT_STEPS      = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               key_space,
   input  logic               key_left,
   input  logic               key_right,
   input  logic               on_ground,
   output logic               jump_req,
   output logic [POWER_W-1:0] jump_power,
   output logic [1:0]         jump_dir,
   output logic               walk_left,
   output logic               walk_right,
   output logic               charging,
   output logic [POWER_W-1:0] charge_lvl
);
   localparam logic [POWER_W-1:0] PMAX = POWER_W'(POWER_MAX);
   localparam logic [POWER_W-1:0] PMIN = POWER_W'(POWER_MIN);
   localparam int STEP_W = $clog2((LAND_STEPS > LIFT_STEPS ? LAND_STEPS : LIFT_STEPS) + 1);
   localparam logic [STEP_W-1:0] LAND_LAST = STEP_W'(LAND_STEPS - 1);
   localparam logic [STEP_W-1:0] LIFT_LAST = STEP_W'(LIFT_STEPS - 1);

   if (POWER_MAX >= 2 ** POWER_W || POWER_MIN > POWER_MAX) begin : g_bad_cfg
      $error("jump_charge_ctl: POWER_MIN/POWER_MAX do not fit POWER_W");
   end

   jump_state_t       state_q, state_d;
   logic [POWER_W-1:0] lvl_q, lvl_d, power_q, power_d;
   logic [STEP_W-1:0]  steps_q, steps_d;
   logic [1:0]         dir_q, dir_d;
   logic               req_q, req_d, wl_q, wl_d, wr_q, wr_d, chg_q, chg_d;
   logic               space_prev_q, step_tick, timer_clr;

   jump_charge_ctl_step_timer #(.CYCLES_PER_STEP(CYCLES_PER_STEP)) u_step_timer (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (timer_clr),
      .step_tick_o (step_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lvl_q        <= '0;
         power_q      <= '0;
         dir_q        <= '0;
         steps_q      <= '0;
         req_q        <= 1'b0;
         wl_q         <= 1'b0;
         wr_q         <= 1'b0;
         chg_q        <= 1'b0;
         space_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         lvl_q        <= lvl_d;
         power_q      <= power_d;
         dir_q        <= dir_d;
         steps_q      <= steps_d;
         req_q        <= req_d;
         wl_q         <= wl_d;
         wr_q         <= wr_d;
         chg_q        <= chg_d;
         space_prev_q <= key_space;
      end
   end

   // losing ground always wins, so a slide-off never launches or finishes a landing
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !on_ground ? AIR : (key_space && !space_prev_q) ? CHARGE : IDLE;
         CHARGE:  state_d = !on_ground ? AIR : (!key_space || lvl_q == PMAX) ? LAUNCH : CHARGE;
         LAUNCH:  state_d = LIFT;
         LIFT:    state_d = !on_ground ? AIR : (step_tick && steps_q == LIFT_LAST) ? LAND : LIFT;
         AIR:     state_d = on_ground ? LAND : AIR;
         LAND:    state_d = !on_ground ? AIR : (step_tick && steps_q == LAND_LAST) ? IDLE : LAND;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      timer_clr = state_d != state_q;
      steps_d   = timer_clr ? '0 : steps_q + STEP_W'(step_tick);
      lvl_d     = (state_d == LAUNCH) ? lvl_q :
                  (state_d != CHARGE || state_q != CHARGE) ? '0 :
                  (step_tick && lvl_q != PMAX) ? lvl_q + POWER_W'(1) : lvl_q;
      power_d   = (state_d == LAUNCH) ? ((lvl_q < PMIN) ? PMIN : lvl_q) : power_q;
      dir_d     = (state_d == LAUNCH) ? pick_dir(key_left, key_right) : dir_q;
      req_d     = state_d == LAUNCH;
      chg_d     = state_d == CHARGE;
      wl_d      = state_d == IDLE && key_left && !key_right;
      wr_d      = state_d == IDLE && key_right && !key_left;
   end

   assign jump_req   = req_q;
   assign jump_power = power_q;
   assign jump_dir   = dir_q;
   assign walk_left  = wl_q;
   assign walk_right = wr_q;
   assign charging   = chg_q;
   assign charge_lvl = lvl_q;
endmodule
